// File: rtl/kgp_pkg.sv
// Shared KGPRISC definitions: call/ret opcodes, address type and helpers
// used by the return-address stack and the branch unit.
package kgp_pkg;

    localparam int ADDR_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [5:0]        opc_t;

    localparam opc_t OPC_CALL = 6'b000110;
    localparam opc_t OPC_RET  = 6'b000111;

    function automatic logic opc_is_call(input opc_t opc);
        return opc == OPC_CALL;
    endfunction

    function automatic logic opc_is_ret(input opc_t opc);
        return opc == OPC_RET;
    endfunction

endpackage

// File: rtl/ra_stack_if.sv
// Return-address stack port bundle: the CPU side (master) drives opcode, PC
// and flush; the stack (slave) returns top-of-stack, occupancy and error flags.
interface ra_stack_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
);
    import kgp_pkg::*;

    opc_t                       instr;
    logic [WIDTH-1:0]           pc;
    logic                       flush;
    logic [WIDTH-1:0]           ra;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       empty;
    logic                       full;
    logic                       ovf_err;
    logic                       udf_err;

    modport master (
        output instr, pc, flush,
        input  ra, count, empty, full, ovf_err, udf_err
    );

    modport slave (
        input  instr, pc, flush,
        output ra, count, empty, full, ovf_err, udf_err
    );

endinterface

// File: rtl/ra_stack_mem.sv
// DEPTH x WIDTH storage for the return-address stack: one synchronous write
// port, one asynchronous read port, no reset (contents gated by count).
module ra_stack_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ra_stack.sv
// Return-address stack: pushes pc+4 on call, pops on ret, circular overwrite
// on overflow. Sticky error flags exist only when RAS_STICKY_ERR_EN is defined.
module ra_stack
    import kgp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       start,
    ra_stack_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    tp;
    logic [PW-1:0]    tp_nxt;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             is_call;
    logic             is_ret;
    logic             empty;
    logic             full;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] top_data;

    // flush suppresses decode entirely so nothing is written on a flush edge
    assign is_call   = !bus.flush && opc_is_call(bus.instr);
    assign is_ret    = !bus.flush && opc_is_ret(bus.instr);
    assign push_data = bus.pc + WIDTH'(4);
    assign rd_ptr    = tp - PW'(1);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_comb begin
        tp_nxt    = tp;
        count_nxt = count;
        if (bus.flush) begin
            tp_nxt    = '0;
            count_nxt = '0;
        end else if (is_call) begin
            tp_nxt = tp + PW'(1);
            if (!full) begin
                count_nxt = count + CW'(1);
            end
        end else if (is_ret && !empty) begin
            tp_nxt    = tp - PW'(1);
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            tp    <= '0;
            count <= '0;
        end else begin
            tp    <= tp_nxt;
            count <= count_nxt;
        end
    end

    ra_stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (is_call),
        .waddr (tp),
        .wdata (push_data),
        .raddr (rd_ptr),
        .rdata (top_data)
    );

    assign bus.ra    = empty ? '0 : top_data;
    assign bus.count = count;
    assign bus.empty = empty;
    assign bus.full  = full;

`ifdef RAS_STICKY_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (is_call && full) begin
                ovf_q <= 1'b1;
            end
            if (is_ret && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
`else
    assign bus.ovf_err = 1'b0;
    assign bus.udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_ra_stack.sv
// Self-checking bench for ra_stack: directed scenarios then random traffic,
// checked against a queue-based model of return-address behaviour.
module tb_ra_stack;
    import kgp_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
`ifdef RAS_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic start;
    always #5 clk = ~clk;

    ra_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    ra_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .start (start),
        .bus   (bus)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    addr_t q[$];
    bit    m_ovf;
    bit    m_udf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic addr_t m_top();
        return (q.size() == 0) ? '0 : q[$];
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_apply(input opc_t op, input addr_t pc, input bit fl);
        if (fl) begin
            q.delete();
        end else if (op == OPC_CALL) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                m_ovf = 1'b1;
            end
            q.push_back(pc + 32'd4);
        end else if (op == OPC_RET) begin
            if (q.size() == 0) m_udf = 1'b1;
            else void'(q.pop_back());
        end
    endtask

    task automatic check_state(input string ctx);
        check({ctx, ":ra"},    64'(bus.ra),      64'(m_top()));
        check({ctx, ":count"}, 64'(bus.count),   64'(q.size()));
        check({ctx, ":empty"}, 64'(bus.empty),   64'(q.size() == 0));
        check({ctx, ":full"},  64'(bus.full),    64'(q.size() == DEPTH));
        check({ctx, ":ovf"},   64'(bus.ovf_err), 64'(STICKY & m_ovf));
        check({ctx, ":udf"},   64'(bus.udf_err), 64'(STICKY & m_udf));
    endtask

    // Called just after a rising edge; applies one op across the next edge.
    task automatic step(input string ctx, input opc_t op, input addr_t pc, input bit fl);
        bus.instr = op;
        bus.pc    = pc;
        bus.flush = fl;
        #1;
        check({ctx, ":pre_ra"}, 64'(bus.ra), 64'(m_top()));
        @(posedge clk);
        model_apply(op, pc, fl);
        #1;
        bus.instr = 6'b000000;
        bus.flush = 1'b0;
        check_state(ctx);
    endtask

    initial begin
        addr_t exp_ra [3];
        start     = 1'b0;
        bus.instr = OPC_CALL;
        bus.pc    = 32'h0000_0500;
        bus.flush = 1'b0;
        model_reset();

        // Reset held with a call on the opcode: nothing must happen
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        start = 1'b1;

        step("first_call", OPC_CALL, 32'h100, 1'b0);
        check("first_call:ra_const", 64'(bus.ra), 64'h104);
        step("first_ret", OPC_RET, 32'h0, 1'b0);

        // Nesting
        step("nest_c0", OPC_CALL, 32'h10, 1'b0);
        step("nest_c1", OPC_CALL, 32'h40, 1'b0);
        step("nest_c2", OPC_CALL, 32'h80, 1'b0);
        exp_ra[0] = 32'h84; exp_ra[1] = 32'h44; exp_ra[2] = 32'h14;
        for (int i = 0; i < 3; i++) begin
            check("nest:ra_const", 64'(bus.ra), 64'(exp_ra[i]));
            step("nest_ret", OPC_RET, 32'h0, 1'b0);
        end
        check("nest:ra_end", 64'(bus.ra), 64'h0);

        // Overflow: 9 calls, oldest entry (pc 0 -> 4) lost
        for (int i = 0; i < 9; i++) step("ovf_call", OPC_CALL, addr_t'(i * 4), 1'b0);
        check("ovf:full", 64'(bus.full), 64'h1);
        check("ovf:count", 64'(bus.count), 64'd8);
        check("ovf:flag", 64'(bus.ovf_err), 64'(STICKY));
        for (int i = 0; i < 8; i++) begin
            check("ovf:pop_ra", 64'(bus.ra), 64'(36 - 4 * i));
            step("ovf_ret", OPC_RET, 32'h0, 1'b0);
        end
        check("ovf:drained_ra", 64'(bus.ra), 64'h0);

        // Underflow
        step("udf_ret", OPC_RET, 32'h0, 1'b0);
        check("udf:flag", 64'(bus.udf_err), 64'(STICKY));
        step("udf_call", OPC_CALL, 32'h200, 1'b0);
        check("udf:ra_const", 64'(bus.ra), 64'h204);

        // PC wrap
        step("wrap_call", OPC_CALL, 32'hFFFF_FFFC, 1'b0);
        check("wrap:ra_const", 64'(bus.ra), 64'h0);

        // Flush beats call
        for (int i = 0; i < 3; i++) step("fl_call", OPC_CALL, addr_t'(32'h300 + i * 16), 1'b0);
        step("flush", OPC_CALL, 32'h700, 1'b1);
        check("flush:count", 64'(bus.count), 64'd0);
        step("after_flush_call", OPC_CALL, 32'h400, 1'b0);
        step("after_flush_call", OPC_CALL, 32'h410, 1'b0);

        // Asynchronous reset between edges
        #2;
        start = 1'b0;
        model_reset();
        #1;
        check_state("async_rst");
        @(posedge clk);
        #1;
        check_state("async_rst_held");
        start = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int    r;
            addr_t pc;
            r  = int'($urandom_range(0, 15));
            pc = addr_t'($urandom) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            if (r < 7)       step("rnd_call", OPC_CALL, pc, 1'b0);
            else if (r < 12) step("rnd_ret", OPC_RET, pc, 1'b0);
            else if (r < 15) step("rnd_nop", opc_t'($urandom_range(8, 63)), pc, 1'b0);
            else             step("rnd_flush", OPC_CALL, pc, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ra_stack.md
# ra_stack

Hardware return-address stack for the KGPRISC single-cycle CPU. Sits beside the branch/PC-update unit: on every `call` it pushes the return address (current PC + 4), and on every `ret` it presents the saved address on `ra` for the PC update at the same clock edge, then pops it. Call/ret decoding is internal, from the same 6-bit opcode field that drives the branch unit, so no extra control wiring is needed.

## Interface
- `DEPTH`, default 8: number of return-address entries; a power of two, at least 2.
- `WIDTH`, default 32: address width.
- `clk`  in  1: CPU clock; all state updates on the rising edge.
- `start`  in  1: reset, asynchronous and active-low. `start`=0 clears all state immediately.
- `instr`  in  6: opcode of the current instruction. `000110` = call, `000111` = ret, all other values = no-op.
- `pc`  in  WIDTH: PC of the current instruction.
- `flush`  in  1: synchronous clear of the whole stack. Takes priority over `instr`.
- `ra`  out  WIDTH: combinational top-of-stack value; 0 when the stack is empty.
- `count`  out  $clog2(DEPTH+1): number of valid entries.
- `empty`  out  1: `count`==0.
- `full`  out  1: `count`==DEPTH.
- `ovf_err`  out  1: sticky overflow flag.
- `udf_err`  out  1: sticky underflow flag.

## Operation
- Storage is a circular buffer of DEPTH words with a top pointer `tp` of width log2(DEPTH).
  - `ra` = `mem[tp-1]` (mod DEPTH) when `count`>0, else 0.
  - The stored address is also visible when `count`>0.
- Call (`instr`=`000110`, `flush`=0):
  - Writes `mem[tp]` = `pc`+4, truncated to WIDTH; `pc`=FFFFFFFC wraps to 0.
  - `tp` increments mod DEPTH.
  - `count` saturates at DEPTH.
  - Call while `full`: the oldest entry is overwritten by the wrap, `count` stays DEPTH, `ovf_err` is set.
- Ret (`instr`=`000111`, `flush`=0):
  - `ra` (pre-edge value) is what the branch unit samples.
  - At the edge, `tp` decrements mod DEPTH and `count` decrements.
  - Ret while `empty`: `tp` and `count` are unchanged, `ra` stays 0, `udf_err` is set.
- Any other opcode: no state change.
- `flush`=1: `tp`=0 and `count`=0 at the next edge. Memory contents are not cleared (they are unobservable). Error flags are not cleared.
- Error flags clear only on reset.

## Timing
- Reset values: `tp`=0, `count`=0, `ra`=0, `empty`=1, `full`=0, `ovf_err`=0, `udf_err`=0. Memory contents are don't-care.
- Deassertion of `start` takes effect at the first following rising edge.
- Push latency is 1 cycle: after a call at edge N, `ra` equals the pushed value from edge N plus combinational delay.
- Back-to-back call→ret:
  - The ret at edge N+1 sees the address pushed at edge N.
  - `count` returns to its prior value after edge N+1.
- Back-to-back ret→ret pops consecutive entries, one per edge.
- `start` asserted mid-sequence: immediate return to reset values. A partially written entry is never reported, because `count`=0.
- `flush` and call on the same edge: flush wins and nothing is pushed.
- `ra`, `empty` and `full` are combinational from registers only, with no path from `instr` or `pc`.

## Configuration
- `RAS_STICKY_ERR_EN` defined:
  - `ovf_err` and `udf_err` are implemented as described above.
- `RAS_STICKY_ERR_EN` undefined:
  - Both flags are tied to 0 and their flops are removed.
  - Overflow still wraps and underflow is still a no-op; only the reporting is removed.

## Structure
- The shared package `kgp_pkg` holds:
  - Opcode constants `OPC_CALL`=6'b000110 and `OPC_RET`=6'b000111, also to be used by the branch unit.
  - The `addr_t` typedef, WIDTH bits.
- One sub-module, `ra_stack_mem`: a DEPTH×WIDTH register array with one synchronous write port, one asynchronous read port, and no reset. The top level contains pointer, count, flag and decode logic only.

## Test plan
- Reset and read: hold `start`=0 with `instr`=call → `count`=0, `empty`=1, `ra`=0. Release `start` → first call with `pc`=0x100 gives `ra`=0x104 and `count`=1.
- Nesting: calls at `pc`=0x10, 0x40, 0x80, then three rets → `ra` reads 0x84, then 0x44, then 0x14, then 0. Final `count`=0, no error flags.
- Overflow (DEPTH=8): 9 calls at `pc`=0,4,…,32 → `full`=1, `ovf_err`=1, `count`=8. Eight rets return 36, 32, …, 8, and the entry 4 is lost.
- Underflow: ret on an empty stack → `udf_err`=1, `count`=0, `ra`=0. A following call at 0x200 gives `ra`=0x204.
- Flush and async reset: 3 calls, then `flush`=1 with `instr`=call → `count`=0 and no push. Then 2 calls, and pull `start` low between edges → outputs return to reset values without waiting for a clock edge.
- Macro off: repeat the overflow and underflow scenarios → same data behaviour, with `ovf_err`=`udf_err`=0 throughout.
